// File: rtl/pl_ifid_queued.sv
// rtl/pl_ifid_queued.sv - IF/ID stage with fetch queue, head decode and registered ID outputs
module pl_ifid_queued #(
    parameter int PROG_CTR_WID = 10,
    parameter int NUM_DOMAINS  = 1,
    parameter int FQ_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_valid,
    input  logic [15:0]               if_instr,
    input  logic [PROG_CTR_WID-1:0]   if_pc,
    output logic                      if_ready,
    input  logic                      flush,
    input  logic                      stall,
    output logic [2:0]                hd_op1_addr,
    output logic [2:0]                hd_op2_addr,
    output logic                      hd_load,
    input  logic [NUM_DOMAINS*8-1:0]  op1_data,
    input  logic [NUM_DOMAINS*8-1:0]  op2_data,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [20:0]               id_ctrl,
    output logic [7:0]                id_ld_addr,
    output logic [7:0]                id_st_addr,
    output logic [PROG_CTR_WID-1:0]   id_br_target,
    output logic [PROG_CTR_WID-1:0]   id_pc,
    output logic [2:0]                id_op1_addr,
    output logic [2:0]                id_op2_addr,
    output logic [2:0]                id_res_addr,
    output logic [NUM_DOMAINS*8-1:0]  id_op1_data,
    output logic [NUM_DOMAINS*8-1:0]  id_op2_data,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    localparam int B_ADD = 0,  B_OR = 1,   B_NOT = 2,   B_ANDB = 3,  B_ORB = 4;
    localparam int B_NOTB = 5, B_AND = 6,  B_CIN = 7,   B_CMPL = 8,  B_JUMP = 9;
    localparam int B_CMP = 10, B_SHL = 11, B_LOGIC = 12, B_STORE = 13, B_LOAD = 14;
    localparam int B_WRF = 15, B_JGT = 16, B_JLT = 17,  B_JEQ = 18,  B_JC = 19;
    localparam int B_UJMP = 20;

    logic [15:0]             fq_instr [FQ_DEPTH];
    logic [PROG_CTR_WID-1:0] fq_pc    [FQ_DEPTH];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [15:0]             head_instr;
    logic                    push, pop;
    logic [20:0]             head_ctrl;

    function automatic logic [20:0] decode(input logic [4:0] opcode);
        logic [20:0] c;
        c = '0;
        case (opcode)
            5'h01: begin c[B_ADD] = 1'b1; c[B_WRF] = 1'b1; end
            5'h02: begin c[B_ADD] = 1'b1; c[B_CIN] = 1'b1; c[B_CMPL] = 1'b1; c[B_WRF] = 1'b1; end
            5'h03: begin c[B_AND] = 1'b1; c[B_LOGIC] = 1'b1; c[B_WRF] = 1'b1; end
            5'h04: begin c[B_OR] = 1'b1; c[B_LOGIC] = 1'b1; c[B_WRF] = 1'b1; end
            5'h05: begin c[B_NOT] = 1'b1; c[B_LOGIC] = 1'b1; c[B_WRF] = 1'b1; end
            5'h06: begin c[B_SHL] = 1'b1; c[B_WRF] = 1'b1; end
            5'h07: begin c[B_JUMP] = 1'b1; c[B_UJMP] = 1'b1; end
            5'h08: begin c[B_LOAD] = 1'b1; c[B_WRF] = 1'b1; end
            5'h09: begin c[B_STORE] = 1'b1; end
            5'h0A: begin c[B_ANDB] = 1'b1; c[B_LOGIC] = 1'b1; c[B_WRF] = 1'b1; end
            5'h0B: begin c[B_ORB] = 1'b1; c[B_LOGIC] = 1'b1; c[B_WRF] = 1'b1; end
            5'h0C: begin c[B_NOTB] = 1'b1; c[B_LOGIC] = 1'b1; c[B_WRF] = 1'b1; end
            5'h0D: begin c[B_ADD] = 1'b1; c[B_CIN] = 1'b1; c[B_CMPL] = 1'b1; c[B_CMP] = 1'b1; end
            5'h0E: begin c[B_JUMP] = 1'b1; c[B_JGT] = 1'b1; end
            5'h0F: begin c[B_JUMP] = 1'b1; c[B_JLT] = 1'b1; end
            5'h10: begin c[B_JUMP] = 1'b1; c[B_JEQ] = 1'b1; end
            5'h11: begin c[B_JUMP] = 1'b1; c[B_JC] = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Full queue never accepts, even if the head pops this same cycle.
    assign if_ready   = (fq_count < CW'(FQ_DEPTH));
    assign push       = if_valid & if_ready;
    assign pop        = (fq_count != '0) & ~stall & (~id_valid | id_ready);
    assign head_instr = fq_instr[rd_ptr];
    assign head_ctrl  = decode(head_instr[15:11]);

    assign hd_op1_addr = head_instr[2:0];
    assign hd_op2_addr = head_instr[6:4];
    assign hd_load     = (fq_count != '0) & head_ctrl[B_LOAD];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fq_count <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_instr[i] <= '0;
                fq_pc[i]    <= '0;
            end
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fq_count <= '0;
        end else begin
            if (push) begin
                fq_instr[wr_ptr] <= if_instr;
                fq_pc[wr_ptr]    <= if_pc;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fq_count <= fq_count + CW'(1);
                2'b01:   fq_count <= fq_count - CW'(1);
                default: fq_count <= fq_count;
            endcase
        end
    end

    // Flush only drops id_valid; stale payload fields are harmless once invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid     <= 1'b0;
            id_ctrl      <= '0;
            id_ld_addr   <= '0;
            id_st_addr   <= '0;
            id_br_target <= '0;
            id_pc        <= '0;
            id_op1_addr  <= '0;
            id_op2_addr  <= '0;
            id_res_addr  <= '0;
            id_op1_data  <= '0;
            id_op2_data  <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (pop) begin
            id_valid     <= 1'b1;
            id_ctrl      <= head_ctrl;
            id_ld_addr   <= head_instr[7:0];
            id_st_addr   <= head_instr[10:3];
            id_br_target <= PROG_CTR_WID'(head_instr[9:0]);
            id_pc        <= fq_pc[rd_ptr];
            id_op1_addr  <= head_instr[2:0];
            id_op2_addr  <= head_instr[6:4];
            id_res_addr  <= head_instr[10:8];
            id_op1_data  <= op1_data;
            id_op2_data  <= op2_data;
        end else if (id_valid & id_ready) begin
            id_valid <= 1'b0;
        end
    end
endmodule
